// File: rtl/conv_layer_ctrl.sv
// rtl/conv_layer_ctrl.sv - address generation and sequencing for one 2-D convolution layer
// Define CONV_PAD_EN for same padding (OUT_W = IN_W) with out-of-bounds tap masking.
module conv_layer_ctrl #(
  parameter int IN_W = 32,
  parameter int IN_C = 3,
  parameter int K    = 5,
  parameter int N_F  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_ctrl,
  output logic [15:0] s_addr,
  output logic [15:0] w_addr,
  output logic [15:0] b_addr,
  output logic [15:0] save_addr,
  output logic        en_sum,
  output logic        en_save,
  output logic        en_read,
  output logic        en_write,
  output logic        s_convout,
  output logic        en_sat,
  output logic        en_mac,
  output logic        en_mult_r,
  output logic        finish
);

`ifdef CONV_PAD_EN
  localparam int PAD   = K / 2;
  localparam int OUT_W = IN_W;
`else
  localparam int OUT_W = IN_W - K + 1;
`endif

  localparam logic [15:0] KM1   = 16'(K - 1);
  localparam logic [15:0] CM1   = 16'(IN_C - 1);
  localparam logic [15:0] OM1   = 16'(OUT_W - 1);
  localparam logic [15:0] FM1   = 16'(N_F - 1);
  localparam logic [15:0] INW16 = 16'(IN_W);
  localparam logic [15:0] INC16 = 16'(IN_C);
  localparam logic [15:0] K16   = 16'(K);
  localparam logic [15:0] OW16  = 16'(OUT_W);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_DRAIN, S_BIAS, S_SAT, S_WRITE, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_f, r_y, r_x, r_c, r_ky, r_kx;
  logic        r_drain;
  logic        r_mult_d1, r_mac_d1, r_mac_d2;

  logic        w_last_tap, w_last_pix, w_abort, w_masked;
  logic [15:0] w_iy, w_ix;
  logic [15:0] w_s_addr, w_w_addr, w_save_addr;

  assign w_last_tap = (r_c == CM1) && (r_ky == KM1) && (r_kx == KM1);
  assign w_last_pix = (r_f == FM1) && (r_y == OM1) && (r_x == OM1);
  assign w_abort    = !en_ctrl && (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef CONV_PAD_EN
  localparam logic signed [16:0] PAD_S = 17'(PAD);
  localparam logic signed [16:0] INW_S = 17'(IN_W);
  logic signed [16:0] w_iy_s, w_ix_s;

  // Input coordinates may go negative at the top/left border; bit 16 is the sign.
  assign w_iy_s   = $signed({1'b0, r_y}) + $signed({1'b0, r_ky}) - PAD_S;
  assign w_ix_s   = $signed({1'b0, r_x}) + $signed({1'b0, r_kx}) - PAD_S;
  assign w_masked = w_iy_s[16] | w_ix_s[16] | (w_iy_s >= INW_S) | (w_ix_s >= INW_S);
  assign w_iy     = w_iy_s[15:0];
  assign w_ix     = w_ix_s[15:0];
`else
  assign w_masked = 1'b0;
  assign w_iy     = r_y + r_ky;
  assign w_ix     = r_x + r_kx;
`endif

  assign w_s_addr    = w_masked ? 16'd0 : (r_c * INW16 + w_iy) * INW16 + w_ix;
  assign w_w_addr    = ((r_f * INC16 + r_c) * K16 + r_ky) * K16 + r_kx;
  assign w_save_addr = (r_f * OW16 + r_y) * OW16 + r_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    s_addr    = '0;
    w_addr    = '0;
    b_addr    = '0;
    save_addr = '0;
    en_sum    = 1'b0;
    en_save   = 1'b0;
    en_read   = 1'b0;
    en_write  = 1'b0;
    s_convout = 1'b0;
    en_sat    = 1'b0;
    finish    = 1'b0;
    en_mult_r = r_mult_d1;
    en_mac    = r_mac_d2;
    case (r_state)
      S_IDLE: begin
        if (en_ctrl) w_next = S_MAC;
      end
      S_MAC: begin
        en_read = 1'b1;
        s_addr  = w_s_addr;
        w_addr  = w_w_addr;
        b_addr  = r_f;
        if (w_last_tap) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        b_addr = r_f;
        if (r_drain) w_next = S_BIAS;
      end
      S_BIAS: begin
        b_addr = r_f;
        en_sum = 1'b1;
        w_next = S_SAT;
      end
      S_SAT: begin
        b_addr    = r_f;
        en_sat    = 1'b1;
        s_convout = 1'b1;
        w_next    = S_WRITE;
      end
      S_WRITE: begin
        b_addr    = r_f;
        save_addr = w_save_addr;
        en_write  = 1'b1;
        en_save   = 1'b1;
        s_convout = 1'b1;
        w_next    = w_last_pix ? S_DONE : S_MAC;
      end
      S_DONE: begin
        finish = 1'b1;
        if (!en_ctrl) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Tap/pixel counters and the product/accumulate delay pipes; abort restarts at pixel (0,0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_abort) begin
      r_f       <= '0;
      r_y       <= '0;
      r_x       <= '0;
      r_c       <= '0;
      r_ky      <= '0;
      r_kx      <= '0;
      r_drain   <= 1'b0;
      r_mult_d1 <= 1'b0;
      r_mac_d1  <= 1'b0;
      r_mac_d2  <= 1'b0;
    end else begin
      r_mult_d1 <= (r_state == S_MAC);
      r_mac_d1  <= (r_state == S_MAC) && !w_masked;
      r_mac_d2  <= r_mac_d1;
      case (r_state)
        S_MAC: begin
          if (r_kx == KM1) begin
            r_kx <= '0;
            if (r_ky == KM1) begin
              r_ky <= '0;
              r_c  <= (r_c == CM1) ? 16'd0 : r_c + 16'd1;
            end else begin
              r_ky <= r_ky + 16'd1;
            end
          end else begin
            r_kx <= r_kx + 16'd1;
          end
        end
        S_DRAIN: r_drain <= ~r_drain;
        S_WRITE: begin
          if (r_x == OM1) begin
            r_x <= '0;
            if (r_y == OM1) begin
              r_y <= '0;
              r_f <= (r_f == FM1) ? 16'd0 : r_f + 16'd1;
            end else begin
              r_y <= r_y + 16'd1;
            end
          end else begin
            r_x <= r_x + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb/tb_conv_layer_ctrl.sv - scoreboard bench for conv_layer_ctrl on a reduced layer (8x8x2, 3x3, 3 filters)
module tb_conv_layer_ctrl;
  localparam int IN_W = 8;
  localparam int IN_C = 2;
  localparam int K    = 3;
  localparam int N_F  = 3;
`ifdef CONV_PAD_EN
  localparam int PAD   = K / 2;
  localparam int OUT_W = IN_W;
`else
  localparam int PAD   = 0;
  localparam int OUT_W = IN_W - K + 1;
`endif
  localparam int TAPS    = IN_C * K * K;
  localparam int PIX_CYC = TAPS + 5;
  localparam int N_PIX   = N_F * OUT_W * OUT_W;

  // strobe vector bit positions
  localparam int B_SUM = 8, B_SAVE = 7, B_READ = 6, B_WRITE = 5, B_CONV = 4;
  localparam int B_SAT = 3, B_MAC = 2, B_MULT = 1, B_FIN = 0;

  logic        clk, reset, en_ctrl;
  logic [15:0] s_addr, w_addr, b_addr, save_addr;
  logic        en_sum, en_save, en_read, en_write, s_convout, en_sat, en_mac, en_mult_r, finish;
  logic [8:0]  got_stb;

  assign got_stb = {en_sum, en_save, en_read, en_write, s_convout, en_sat, en_mac, en_mult_r, finish};

  conv_layer_ctrl #(.IN_W(IN_W), .IN_C(IN_C), .K(K), .N_F(N_F)) dut (
    .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
    .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
    .en_sum(en_sum), .en_save(en_save), .en_read(en_read), .en_write(en_write),
    .s_convout(s_convout), .en_sat(en_sat), .en_mac(en_mac), .en_mult_r(en_mult_r),
    .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  stb;
    logic [15:0] s_addr, w_addr, b_addr, save_addr;
    bit chk_rd, chk_busy, chk_wr, start;
  } exp_t;

  typedef struct {
    int idx;
    int fld;
    int val;
  } hand_t;

  exp_t  sb_q[$];
  hand_t hand_q[$];
  int checks = 0;
  int failures = 0;

  function automatic bit tap_masked(input int y, input int x, input int t);
    int ky, kx, iy, ix;
    ky = (t / K) % K;
    kx = t % K;
    iy = y + ky - PAD;
    ix = x + kx - PAD;
    return (iy < 0) || (iy >= IN_W) || (ix < 0) || (ix >= IN_W);
  endfunction

  function automatic exp_t zero_rec();
    exp_t e;
    e.stb = '0; e.s_addr = '0; e.w_addr = '0; e.b_addr = '0; e.save_addr = '0;
    e.chk_rd = 0; e.chk_busy = 0; e.chk_wr = 0; e.start = 0;
    return e;
  endfunction

  // Expected per-cycle output for cycle t (0..PIX_CYC-1) of pixel (f,y,x).
  function automatic exp_t pix_rec(input int f, input int y, input int x, input int t);
    exp_t e;
    int c, ky, kx;
    e = zero_rec();
    e.chk_busy = 1;
    e.b_addr = 16'(f);
    if (t < TAPS) begin
      c = t / (K * K);
      ky = (t / K) % K;
      kx = t % K;
      e.stb[B_READ] = 1'b1;
      e.chk_rd = 1;
      e.s_addr = tap_masked(y, x, t) ? 16'd0
               : 16'((c * IN_W + (y + ky - PAD)) * IN_W + (x + kx - PAD));
      e.w_addr = 16'(((f * IN_C + c) * K + ky) * K + kx);
    end
    if (t >= 1 && t <= TAPS) e.stb[B_MULT] = 1'b1;
    if (t >= 2 && t <= TAPS + 1) e.stb[B_MAC] = !tap_masked(y, x, t - 2);
    if (t == TAPS + 2) e.stb[B_SUM] = 1'b1;
    if (t == TAPS + 3) begin
      e.stb[B_SAT] = 1'b1;
      e.stb[B_CONV] = 1'b1;
    end
    if (t == TAPS + 4) begin
      e.stb[B_WRITE] = 1'b1;
      e.stb[B_SAVE] = 1'b1;
      e.stb[B_CONV] = 1'b1;
      e.chk_wr = 1;
      e.save_addr = 16'((f * OUT_W + y) * OUT_W + x);
    end
    return e;
  endfunction

  task automatic push_run(input int limit, input bit with_done);
    int n;
    exp_t e;
    n = 0;
    for (int f = 0; f < N_F; f++)
      for (int y = 0; y < OUT_W; y++)
        for (int x = 0; x < OUT_W; x++)
          for (int t = 0; t < PIX_CYC; t++)
            if (n < limit) begin
              e = pix_rec(f, y, x, t);
              e.start = (n == 0);
              sb_q.push_back(e);
              n++;
            end
    if (with_done)
      for (int i = 0; i < 3; i++) begin
        e = zero_rec();
        e.stb[B_FIN] = 1'b1;
        sb_q.push_back(e);
      end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(zero_rec());
  endtask

  task automatic wait_drain(input int budget, input string what);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s: %0d records still pending, required 0", what, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic add_hand(input int i, input int fld, input int v);
    hand_t h;
    h.idx = i; h.fld = fld; h.val = v;
    hand_q.push_back(h);
  endtask

  function automatic int dut_field(input int fld);
    case (fld)
      0: return int'(s_addr);
      1: return int'(w_addr);
      2: return int'(b_addr);
      3: return int'(save_addr);
      4: return int'(en_mac);
      default: return int'(en_write);
    endcase
  endfunction

  // Monitor: pops one expected record per cycle while the scoreboard holds any.
  initial begin
    int run_idx;
    exp_t e;
    hand_t h;
    run_idx = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        run_idx = e.start ? 0 : run_idx + 1;
        checks++;
        if (got_stb !== e.stb) begin
          failures++;
          $display("FAIL strobes idx=%0d got=%b required=%b", run_idx, got_stb, e.stb);
        end
        if (e.chk_rd) begin
          checks += 2;
          if (s_addr !== e.s_addr) begin
            failures++;
            $display("FAIL s_addr idx=%0d got=%0d required=%0d", run_idx, s_addr, e.s_addr);
          end
          if (w_addr !== e.w_addr) begin
            failures++;
            $display("FAIL w_addr idx=%0d got=%0d required=%0d", run_idx, w_addr, e.w_addr);
          end
        end
        if (e.chk_busy) begin
          checks++;
          if (b_addr !== e.b_addr) begin
            failures++;
            $display("FAIL b_addr idx=%0d got=%0d required=%0d", run_idx, b_addr, e.b_addr);
          end
        end
        if (e.chk_wr) begin
          checks++;
          if (save_addr !== e.save_addr) begin
            failures++;
            $display("FAIL save_addr idx=%0d got=%0d required=%0d", run_idx, save_addr, e.save_addr);
          end
        end
        while (hand_q.size() > 0 && hand_q[0].idx == run_idx) begin
          h = hand_q.pop_front();
          checks++;
          if (dut_field(h.fld) != h.val) begin
            failures++;
            $display("FAIL hand_vec idx=%0d field=%0d got=%0d required=%0d",
                     h.idx, h.fld, dut_field(h.fld), h.val);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    en_ctrl = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({got_stb, s_addr, w_addr, b_addr, save_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0", {got_stb, s_addr, w_addr, b_addr, save_addr});
    end
    reset = 1'b0;
    push_idle(2);
    wait_drain(20, "idle0");

    // reset asserted while the 10th tap is on the bus
    en_ctrl = 1'b1;
    push_run(10, 1'b0);
    wait_drain(100, "rst_run");
    reset = 1'b1;
    en_ctrl = 1'b0;
    #1;
    checks++;
    if ({got_stb, s_addr, w_addr, b_addr, save_addr} !== '0) begin
      failures++;
      $display("FAIL reset_mid_mac got=%h required=0", {got_stb, s_addr, w_addr, b_addr, save_addr});
    end
    @(negedge clk);
    reset = 1'b0;
    push_idle(2);
    wait_drain(20, "idle1");

    // restart from pixel 0, then abort inside the second pixel's MAC phase
    en_ctrl = 1'b1;
    push_run(PIX_CYC + 7, 1'b0);
    wait_drain(200, "abort_run");
    en_ctrl = 1'b0;
    push_idle(3);
    wait_drain(20, "idle2");

    // full layer with hand-computed spot vectors (fields: 0 s,1 w,2 b,3 save,4 mac,5 write)
`ifdef CONV_PAD_EN
    add_hand(0, 0, 0);     add_hand(0, 1, 0);     add_hand(2, 4, 0);
    add_hand(4, 0, 0);     add_hand(4, 1, 4);     add_hand(6, 4, 1);
    add_hand(22, 5, 1);    add_hand(22, 3, 0);    add_hand(45, 3, 1);
    add_hand(423, 0, 73);  add_hand(423, 1, 9);   add_hand(425, 4, 1);
    add_hand(1472, 1, 18); add_hand(1494, 2, 1);  add_hand(1494, 3, 64);
    add_hand(4415, 3, 191);
`else
    add_hand(0, 0, 0);     add_hand(0, 1, 0);     add_hand(2, 4, 1);
    add_hand(4, 0, 9);     add_hand(4, 1, 4);
    add_hand(22, 5, 1);    add_hand(22, 3, 0);    add_hand(45, 3, 1);
    add_hand(331, 0, 82);  add_hand(331, 1, 9);   add_hand(333, 4, 1);
    add_hand(828, 1, 18);  add_hand(850, 2, 1);   add_hand(850, 3, 36);
    add_hand(2483, 3, 107);
`endif
    en_ctrl = 1'b1;
    push_run(N_PIX * PIX_CYC, 1'b1);
    wait_drain(N_PIX * PIX_CYC + 100, "full_run");
    en_ctrl = 1'b0;
    push_idle(2);
    wait_drain(20, "idle3");
    checks++;
    if (hand_q.size() != 0) begin
      failures++;
      $display("FAIL hand_pending got=%0d required=0", hand_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Address-generation and sequencing controller for one 2-D convolution layer (default conv1: 32×32×3 input, 5×5 kernels, 32 filters, 32×32×32 output). It drives read addresses into the input, weight and bias RAMs, and strobes the `convolve` MAC datapath. It writes one saturated 8-bit result per output pixel into the output RAM. It sits between the layer memories (`ram`, 1-cycle synchronous read) and the `convolve` datapath.

## Interface
Parameters:
- `IN_W`, 32, input width/height (square)
- `IN_C`, 3, input channels
- `K`, 5, kernel size (square, odd)
- `N_F`, 32, filter count

Ports:
- `clk`, input, 1, single clock, rising edge
- `reset`, input, 1, asynchronous, active-high
- `en_ctrl`, input, 1, level run enable
- `s_addr`, output, 16, input RAM address, CHW: (c·IN_W+iy)·IN_W+ix
- `w_addr`, output, 16, weight address: ((f·IN_C+c)·K+ky)·K+kx
- `b_addr`, output, 16, bias address = f
- `save_addr`, output, 16, output address: (f·OUT_W+y)·OUT_W+x
- `en_sum`, output, 1, add bias into accumulator
- `en_save`, output, 1, pixel-complete marker
- `en_read`, output, 1, read enable for input/weight RAMs
- `en_write`, output, 1, output RAM write strobe (convolve clears accumulator after it)
- `s_convout`, output, 1, select saturated result onto `convout`
- `en_sat`, output, 1, saturate accumulator to signed 8 bit
- `en_mac`, output, 1, accumulate registered product
- `en_mult_r`, output, 1, register multiplier product
- `finish`, output, 1, layer complete

## Operation
- Loop order, outermost first: f (0..N_F-1), y, x (0..OUT_W-1), then taps c, ky, kx (kx fastest). 75 taps/pixel by default.
- iy = y+ky−PAD, ix = x+kx−PAD. A tap is masked when iy or ix is outside 0..IN_W−1.
- For a masked tap, `s_addr` = 0, `en_read` stays high, and the tap's delayed `en_mac` slot is forced low (contributes zero).
- States:
  - IDLE: all outputs 0. Go to MAC when `en_ctrl`=1.
  - MAC: one tap per cycle, `en_read`=1, IN_C·K·K cycles.
  - DRAIN: 2 cycles.
  - BIAS: `en_sum`=1.
  - SAT: `en_sat`=1, `s_convout`=1.
  - WRITE: `en_write`=`en_save`=`s_convout`=1, `save_addr` valid. Advance x/y/f. Go to MAC, or to DONE after the last pixel.
  - DONE: `finish`=1. Go to IDLE when `en_ctrl`=0.
- `en_mult_r` = MAC-state flag delayed 1 cycle. `en_mac` = unmasked MAC-state flag delayed 2 cycles.
- `b_addr` = f, held constant throughout each pixel.
- `en_ctrl`=0 in any state other than IDLE/DONE aborts: go to IDLE, clear counters and delay pipes. The next start restarts at pixel (0,0,0).
- Counters wrap with no overflow: the last tap/pixel/filter is detected by compare, never by wrap.

## Timing
- Reset: every output 0, state IDLE, all counters 0.
- `en_ctrl` sampled high in IDLE at edge n → first tap address driven in cycle n+1.
- Per pixel: 75 MAC + 2 DRAIN + BIAS + SAT + WRITE = 80 cycles.
- First `en_write` occurs 80 cycles after leaving IDLE.
- Full layer: 32·32·32·80 = 2,621,440 cycles, then `finish` rises the next cycle.
- RAM data for a tap address issued in cycle t is valid in t+1. The product is registered at t+1 (`en_mult_r`) and accumulated at t+2 (`en_mac`).

## Configuration
- `CONV_PAD_EN` defined: PAD = K/2 and OUT_W = IN_W (same padding, 32×32 output). Out-of-bounds taps are masked.
- `CONV_PAD_EN` undefined: PAD = 0 and OUT_W = IN_W−K+1 (28×28). Masking logic is absent and `en_mac` is never masked.

## Test plan
- Reset asserted mid-MAC → all outputs 0 immediately; IDLE after release; `en_ctrl`=1 restarts with first tap `w_addr`=0.
- Pixel (f0,y0,x0), padded build:
  - taps 0–11 masked: `en_mac` low for their slots
  - tap 12 (c0,ky2,kx2): `s_addr`=0, `w_addr`=12, `en_mac` high two cycles later
  - `en_write` at cycle 80 with `save_addr`=0
- Second pixel: `save_addr`=1. Filter 1 first write: `save_addr`=1024, `b_addr`=1, first `w_addr`=75.
- Interior pixel (y5,x5), tap c1,ky0,kx0: `s_addr`=1024+3·32+3=1123, `w_addr`=25, unmasked.
- Drop `en_ctrl` during MAC → IDLE next cycle, strobes 0. Full run: `finish` after 2,621,440 cycles, held until `en_ctrl`=0.
- `CONV_PAD_EN` undefined: 28·28·32 writes, last `save_addr`=25087, `en_mac` never masked.
